// File: rtl/ifu_inst_buffer_pkg.sv
// rtl/ifu_inst_buffer_pkg.sv - shared widths and entry type for the instruction buffer
`ifndef BLOCK_INST_SIZE
`define BLOCK_INST_SIZE 8
`endif

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

`ifndef FSQ_WIDTH
`define FSQ_WIDTH 6
`endif

package ifu_inst_buffer_pkg;

    localparam int IBUF_IN_W  = `BLOCK_INST_SIZE;
    localparam int IBUF_OUT_W = `FETCH_WIDTH;
    localparam int IBUF_FSQ_W = `FSQ_WIDTH;

    localparam int IBUF_DEPTH = 32;
    localparam int IBUF_OFS_W = $clog2(IBUF_IN_W);

    // One buffered instruction: raw word, owning fetch stream, slot in its block,
    // and the misaligned-fetch exception flag (set on the first slot of a block only).
    typedef struct packed {
        logic [31:0]           inst;
        logic [IBUF_FSQ_W-1:0] fsq_idx;
        logic [IBUF_OFS_W-1:0] offset;
        logic                  iam;
    } ibuf_entry_t;

endpackage

// File: rtl/ifu_inst_buffer_if.sv
// rtl/ifu_inst_buffer_if.sv - predecode-to-decode bus of the instruction buffer
// master: frontend/backend side (drives in_*, redirect, stall)
// slave : buffer side (drives ibuf_full, out_*)
interface ifu_inst_buffer_if
    import ifu_inst_buffer_pkg::*;
#(
    parameter int IN_W  = IBUF_IN_W,
    parameter int OUT_W = IBUF_OUT_W,
    parameter int FSQ_W = IBUF_FSQ_W
);
    logic [IN_W-1:0]                 in_en;
    logic [$clog2(IN_W):0]           in_num;
    logic [IN_W*32-1:0]              in_inst;
    logic                            in_iam;
    logic [FSQ_W-1:0]                in_fsqIdx;
    logic                            redirect;
    logic                            stall;
    logic                            ibuf_full;
    logic [OUT_W-1:0]                out_en;
    logic [OUT_W*32-1:0]             out_inst;
    logic [OUT_W*FSQ_W-1:0]          out_fsqIdx;
    logic [OUT_W*$clog2(IN_W)-1:0]   out_offset;
    logic [OUT_W-1:0]                out_iam;

    modport master (
        output in_en, in_num, in_inst, in_iam, in_fsqIdx, redirect, stall,
        input  ibuf_full, out_en, out_inst, out_fsqIdx, out_offset, out_iam
    );

    modport slave (
        input  in_en, in_num, in_inst, in_iam, in_fsqIdx, redirect, stall,
        output ibuf_full, out_en, out_inst, out_fsqIdx, out_offset, out_iam
    );
endinterface

// File: rtl/ifu_inst_buffer_compact.sv
// rtl/ifu_inst_buffer_compact.sv - prefix-sum of the slot mask giving each set slot its write rank
// in_en : per-slot valid mask
// rank  : number of set slots strictly below each slot (meaningful only where in_en is set)
module ifu_inst_buffer_compact #(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0]                    in_en,
    output logic [IN_W-1:0][$clog2(IN_W)-1:0]  rank
);
    localparam int RW = $clog2(IN_W);

    logic [RW-1:0] acc;

    // The running sum may wrap after the last slot when all slots are set;
    // that final value is never consumed.
    always_comb begin
        acc  = '0;
        rank = '0;
        for (int s = 0; s < IN_W; s++) begin
            rank[s] = acc;
            acc     = acc + RW'(in_en[s]);
        end
    end
endmodule

// File: rtl/ifu_inst_buffer.sv
// rtl/ifu_inst_buffer.sv - circular instruction buffer between predecode and decode
// clk, rst : single clock, synchronous active-high reset
// bus      : ifu_inst_buffer_if.slave (enqueue block in, dequeue lanes out, ibuf_full, redirect, stall)
// IBUF_PERF_EN defined adds perf_full_cycles, perf_stall_cycles, perf_empty_cycles outputs.
module ifu_inst_buffer
    import ifu_inst_buffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int OUT_W = IBUF_OUT_W
) (
    input  logic               clk,
    input  logic               rst,
    ifu_inst_buffer_if.slave   bus
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]        perf_full_cycles,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_empty_cycles
`endif
);
    localparam int IN_W  = IBUF_IN_W;
    localparam int FSQ_W = IBUF_FSQ_W;
    localparam int OFS_W = IBUF_OFS_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int NW    = $clog2(IN_W) + 1;

    ibuf_entry_t                   mem [DEPTH];
    logic [PW-1:0]                 head;
    logic [PW-1:0]                 tail;
    logic [PW-1:0]                 count;
    logic [PW-1:0]                 deq_num;
    logic                          ibuf_full;
    logic                          enq;
    logic [IN_W-1:0][OFS_W-1:0]    rank;
    logic [IN_W-1:0][AW-1:0]       wr_idx;
    logic [OUT_W-1:0][AW-1:0]      rd_idx;

    ifu_inst_buffer_compact #(.IN_W(IN_W)) u_compact (
        .in_en (bus.in_en),
        .rank  (rank)
    );

    // Wrap bits make tail - head exact over PW bits, so full and empty differ.
    assign count     = tail - head;
    assign ibuf_full = count > PW'(DEPTH - IN_W);
    assign enq       = (|bus.in_en) && !bus.redirect && !ibuf_full;
    assign deq_num   = (count > PW'(OUT_W)) ? PW'(OUT_W) : count;

    assign bus.ibuf_full = ibuf_full;

    // Slot addresses are taken modulo DEPTH by truncation to AW bits, which
    // splits a block that straddles the end of the array.
    always_comb begin
        wr_idx = '0;
        for (int s = 0; s < IN_W; s++) begin
            wr_idx[s] = tail[AW-1:0] + AW'(rank[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq) begin
                tail <= tail + {{(PW-NW){1'b0}}, bus.in_num};
            end
            if (!bus.stall) begin
                head <= head + deq_num;
            end
        end
    end

    // Payload is deliberately not reset; validity comes from head/tail only.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            for (int s = 0; s < IN_W; s++) begin
                if (bus.in_en[s]) begin
                    mem[wr_idx[s]] <= '{
                        inst:    bus.in_inst[s*32 +: 32],
                        fsq_idx: bus.in_fsqIdx,
                        offset:  OFS_W'(s),
                        iam:     bus.in_iam && (rank[s] == '0)
                    };
                end
            end
        end
    end

    always_comb begin
        rd_idx         = '0;
        bus.out_en     = '0;
        bus.out_inst   = '0;
        bus.out_fsqIdx = '0;
        bus.out_offset = '0;
        bus.out_iam    = '0;
        for (int i = 0; i < OUT_W; i++) begin
            rd_idx[i]                        = head[AW-1:0] + AW'(i);
            bus.out_en[i]                    = PW'(i) < count;
            bus.out_inst[i*32 +: 32]         = mem[rd_idx[i]].inst;
            bus.out_fsqIdx[i*FSQ_W +: FSQ_W] = mem[rd_idx[i]].fsq_idx;
            bus.out_offset[i*OFS_W +: OFS_W] = mem[rd_idx[i]].offset;
            bus.out_iam[i]                   = mem[rd_idx[i]].iam;
        end
    end

`ifdef IBUF_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_cycles  <= '0;
            perf_stall_cycles <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (ibuf_full) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if (bus.stall && (count != '0)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (count == '0) begin
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            end
        end
    end
`endif

    // The frontend must never present a block while the buffer reports full.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !((|bus.in_en) && ibuf_full));

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// tb/tb_ifu_inst_buffer.sv - scoreboard bench for ifu_inst_buffer
module tb_ifu_inst_buffer;
    import ifu_inst_buffer_pkg::*;

    localparam int IN_W  = IBUF_IN_W;
    localparam int OUT_W = IBUF_OUT_W;
    localparam int FSQ_W = IBUF_FSQ_W;
    localparam int OFS_W = IBUF_OFS_W;
    localparam int DEPTH = IBUF_DEPTH;
    localparam int NW    = $clog2(IN_W) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_inst_buffer_if bus ();

`ifdef IBUF_PERF_EN
    logic [31:0] perf_full_cycles, perf_stall_cycles, perf_empty_cycles;
`endif

    ifu_inst_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IBUF_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    ibuf_entry_t q [$];
    int errors = 0;
    int checks = 0;
    int blk    = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one block for one cycle; expected entries enter the scoreboard
    // once the capturing edge has passed.
    task automatic drive(input logic [IN_W-1:0] en, input logic iam, input logic [FSQ_W-1:0] fsq,
                         input logic redir, input logic stl);
        ibuf_entry_t pend [$];
        logic [IN_W-1:0] e;
        bit first;
        e = en;
        if (!redir && (q.size() > DEPTH - IN_W)) e = '0;
        first = 1'b1;
        blk++;
        for (int s = 0; s < IN_W; s++) begin
            bus.in_inst[s*32 +: 32] = {16'(blk), 8'hA5, 8'(s)};
            if (e[s] && !redir) begin
                pend.push_back('{inst: {16'(blk), 8'hA5, 8'(s)}, fsq_idx: fsq,
                                 offset: OFS_W'(s), iam: iam && first});
                first = 1'b0;
            end
        end
        bus.in_en     = e;
        bus.in_num    = NW'($countones(e));
        bus.in_iam    = iam;
        bus.in_fsqIdx = fsq;
        bus.redirect  = redir;
        bus.stall     = stl;
        @(posedge clk);
        #1;
        if (redir) q.delete();
        foreach (pend[k]) q.push_back(pend[k]);
        bus.in_en    = '0;
        bus.in_num   = '0;
        bus.in_iam   = 1'b0;
        bus.redirect = 1'b0;
    endtask

    task automatic idle(input int n, input logic stl);
        for (int k = 0; k < n; k++) drive('0, 1'b0, '0, 1'b0, stl);
    endtask

    // Monitor: compares every presented lane with the scoreboard head and pops
    // what the buffer actually releases (only when not stalled).
    initial begin
        logic [OUT_W-1:0] exp_en;
        logic [63:0] act;
        int n;
        wait (mon_on);
        forever begin
            @(negedge clk);
            n = (q.size() < OUT_W) ? q.size() : OUT_W;
            exp_en = '0;
            for (int i = 0; i < n; i++) exp_en[i] = 1'b1;
            check("out_en", 64'(bus.out_en), 64'(exp_en));
            check("ibuf_full", 64'(bus.ibuf_full), 64'(q.size() > DEPTH - IN_W));
            for (int i = 0; i < n; i++) begin
                act = 64'({bus.out_inst[i*32 +: 32], bus.out_fsqIdx[i*FSQ_W +: FSQ_W],
                           bus.out_offset[i*OFS_W +: OFS_W], bus.out_iam[i]});
                check($sformatf("lane%0d", i), act, 64'(q[i]));
            end
            if (!bus.stall) for (int i = 0; i < n; i++) void'(q.pop_front());
        end
    end

    initial begin
        bus.in_en = '0; bus.in_num = '0; bus.in_inst = '0; bus.in_iam = 1'b0;
        bus.in_fsqIdx = '0; bus.redirect = 1'b0; bus.stall = 1'b0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // full block, two dequeue beats
        drive(8'hFF, 1'b0, 6'd3, 1'b0, 1'b0);
        idle(3, 1'b0);
        // sparse block, iam only on lowest slot
        drive(8'b1010_0100, 1'b1, 6'd5, 1'b0, 1'b0);
        idle(2, 1'b0);
        // fill under stall until full, then drain
        for (int k = 0; k < 5; k++) drive(8'hFF, 1'b0, 6'(7 + k), 1'b0, 1'b1);
        idle(2, 1'b1);
        idle(10, 1'b0);
        // redirect with 12 held entries and a simultaneous push
        drive(8'hFF, 1'b0, 6'd20, 1'b0, 1'b1);
        drive(8'h0F, 1'b0, 6'd21, 1'b0, 1'b1);
        drive(8'hFF, 1'b1, 6'd22, 1'b1, 1'b1);
        drive(8'h0F, 1'b0, 6'd23, 1'b0, 1'b0);
        idle(2, 1'b0);
        // redirect back to zero, then walk tail to 30 and straddle the wrap
        drive('0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) drive(8'h0F, 1'b0, 6'(30 + k), 1'b0, 1'b0);
        drive(8'h03, 1'b0, 6'd40, 1'b0, 1'b0);
        drive(8'hFF, 1'b1, 6'd41, 1'b0, 1'b0);
        idle(3, 1'b0);
        // steady four per cycle using upper slots
        for (int k = 0; k < 4; k++) drive(8'hF0, 1'b0, 6'(50 + k), 1'b0, 1'b0);
        idle(1, 1'b0);
        // reset in mid-operation discards held entries
        drive(8'hFF, 1'b0, 6'd60, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
        drive(8'h81, 1'b1, 6'd61, 1'b0, 1'b0);
        idle(2, 1'b0);

        for (int k = 0; k < 50 && q.size() != 0; k++) idle(1, 1'b0);
        check("drain", 64'(q.size()), 64'd0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
